// File: rtl/sobel_gcd_sched_pkg.sv
// Shared types and constants for the GCD / Sobel job scheduler.
package sobel_gcd_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GCD_RUN = 3'd1,
    ST_PX_PREP = 3'd2,
    ST_PX_RUN  = 3'd3,
    ST_DONE    = 3'd4
  } sched_state_t;

  // One-hot grant encodings: bit0 = GCD core, bit1 = Sobel core.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_GCD  = 2'b01;
  localparam logic [1:0] GRANT_PX   = 2'b10;

  // Job type identifiers as reported on done_id_o.
  localparam logic JOB_GCD = 1'b0;
  localparam logic JOB_PX  = 1'b1;

  // Width of the per-job cycle counter (covers TIMEOUT_CYCLES up to 65535).
  localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/sobel_gcd_sched_rr_arbiter.sv
// Two-requester round-robin arbiter. The grant is a pure function of the
// request levels and the last-grant register; the scheduler only samples it
// while idle and registers the result, so no input reaches a block output.
module sched_rr_arbiter
  import sobel_gcd_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req_gcd,
  input  logic       req_px,
  input  logic       update,
  input  logic       update_id,
  output logic [1:0] grant
);

  // 1 = the Sobel core was granted last, so GCD wins the next tie.
  logic last_px_r;

  // Last-grant register: reset favours GCD, updated once per finished job.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_px_r <= 1'b1;
    end else if (update) begin
      last_px_r <= update_id;
    end else begin
      last_px_r <= last_px_r;
    end
  end

  // Grant selection: a single requester always wins, a tie goes to the
  // type that was not granted last.
  always_comb begin
    grant = GRANT_NONE;
    if (req_gcd && req_px) begin
      if (last_px_r) begin
        grant = GRANT_GCD;
      end else begin
        grant = GRANT_PX;
      end
    end else if (req_gcd) begin
      grant = GRANT_GCD;
    end else if (req_px) begin
      grant = GRANT_PX;
    end else begin
      grant = GRANT_NONE;
    end
  end

endmodule

// File: rtl/sobel_gcd_sched.sv
// Job scheduler that time-shares the GCD and Sobel cores. It arbitrates
// requests while idle, sequences the Sobel prep/run enables, aborts jobs that
// exceed a cycle budget and counts normally completed jobs. Every output is a
// register written by the FSM block.
module sobel_gcd_sched
  import sobel_gcd_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned PREP_CYCLES    = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       gcd_req_i,
  input  logic       px_req_i,
  input  logic       gcd_done_i,
  input  logic       pixel_completed_i,
  input  logic       clear_err_i,
  output logic       gcd_enable_o,
  output logic       prep_allowed_o,
  output logic       pixel_enable_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       done_id_o,
  output logic       timeout_err_o,
  output logic [7:0] jobs_done_o
);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT  = TIMEOUT_CYCLES[TMO_CNT_W-1:0];
  localparam logic [TMO_CNT_W-1:0] PREP_LIMIT = PREP_CYCLES[TMO_CNT_W-1:0];

  sched_state_t         state_r;
  logic [TMO_CNT_W-1:0] cnt_r;
  logic [TMO_CNT_W-1:0] cnt_next_s;
  logic [1:0]           arb_grant_s;
  logic                 update_s;
  logic                 tmo_hit_s;
  logic                 complete_s;
  logic                 abort_s;
  logic                 prep_end_s;
  logic                 job_end_s;

  // The last-grant register follows the job type reported while in DONE.
  assign update_s = (state_r == ST_DONE);

  sched_rr_arbiter u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_gcd   (gcd_req_i),
    .req_px    (px_req_i),
    .update    (update_s),
    .update_id (done_id_o),
    .grant     (arb_grant_s)
  );

  // Job-end decode: completion only counts in the matching RUN state and
  // beats a timeout landing on the same cycle.
  always_comb begin
    cnt_next_s = cnt_r + 16'd1;
    tmo_hit_s  = (cnt_next_s == TMO_LIMIT);
    complete_s = 1'b0;
    abort_s    = 1'b0;
    prep_end_s = 1'b0;
    case (state_r)
      ST_GCD_RUN: begin
        complete_s = gcd_done_i;
        abort_s    = tmo_hit_s & ~gcd_done_i;
      end
      ST_PX_PREP: begin
        abort_s    = tmo_hit_s;
        prep_end_s = (cnt_next_s == PREP_LIMIT) & ~tmo_hit_s;
      end
      ST_PX_RUN: begin
        complete_s = pixel_completed_i;
        abort_s    = tmo_hit_s & ~pixel_completed_i;
      end
      default: begin
        complete_s = 1'b0;
        abort_s    = 1'b0;
        prep_end_s = 1'b0;
      end
    endcase
    job_end_s = complete_s | abort_s;
  end

  // Scheduler FSM with registered outputs, job counter and sticky abort flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 16'd0;
      gcd_enable_o   <= 1'b0;
      prep_allowed_o <= 1'b0;
      pixel_enable_o <= 1'b0;
      grant_o        <= GRANT_NONE;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      done_id_o      <= 1'b0;
      timeout_err_o  <= 1'b0;
      jobs_done_o    <= 8'd0;
    end else begin
      done_o <= 1'b0;
      if (clear_err_i) begin
        timeout_err_o <= 1'b0;
      end
      if (job_end_s) begin
        // Finish the job: drop every enable and report it for one cycle.
        state_r        <= ST_DONE;
        gcd_enable_o   <= 1'b0;
        prep_allowed_o <= 1'b0;
        pixel_enable_o <= 1'b0;
        grant_o        <= GRANT_NONE;
        done_o         <= 1'b1;
        done_id_o      <= (state_r == ST_GCD_RUN) ? JOB_GCD : JOB_PX;
        if (complete_s) begin
          jobs_done_o <= jobs_done_o + 8'd1;
        end
        if (abort_s) begin
          // Placed after the clear so a coinciding abort keeps the flag set.
          timeout_err_o <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            cnt_r <= 16'd0;
            case (arb_grant_s)
              GRANT_GCD: begin
                state_r      <= ST_GCD_RUN;
                grant_o      <= GRANT_GCD;
                gcd_enable_o <= 1'b1;
                busy_o       <= 1'b1;
              end
              GRANT_PX: begin
                state_r        <= ST_PX_PREP;
                grant_o        <= GRANT_PX;
                prep_allowed_o <= 1'b1;
                busy_o         <= 1'b1;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
          ST_GCD_RUN, ST_PX_RUN: begin
            cnt_r <= cnt_next_s;
          end
          ST_PX_PREP: begin
            // The counter runs on through prep so the budget spans the job.
            cnt_r <= cnt_next_s;
            if (prep_end_s) begin
              state_r        <= ST_PX_RUN;
              pixel_enable_o <= 1'b1;
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            busy_o  <= 1'b0;
          end
          default: begin
            state_r        <= ST_IDLE;
            gcd_enable_o   <= 1'b0;
            prep_allowed_o <= 1'b0;
            pixel_enable_o <= 1'b0;
            grant_o        <= GRANT_NONE;
            busy_o         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobel_gcd_sched.sv
// Scoreboard bench for sobel_gcd_sched. Instance A uses default parameters,
// instance B uses an 8-cycle timeout; the idle instance is held in reset.
module tb_sobel_gcd_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, reset_b;
  logic gcd_req, px_req, gcd_done, pix_done, clear_err;

  logic       gcd_en_a, prep_a, pix_a, busy_a, done_a, done_id_a, err_a;
  logic [1:0] grant_a;
  logic [7:0] jobs_a;
  logic       gcd_en_b, prep_b, pix_b, busy_b, done_b, done_id_b, err_b;
  logic [1:0] grant_b;
  logic [7:0] jobs_b;

  sobel_gcd_sched dut_a (
    .clk_i(clk), .reset_i(reset_a), .gcd_req_i(gcd_req), .px_req_i(px_req),
    .gcd_done_i(gcd_done), .pixel_completed_i(pix_done), .clear_err_i(clear_err),
    .gcd_enable_o(gcd_en_a), .prep_allowed_o(prep_a), .pixel_enable_o(pix_a),
    .grant_o(grant_a), .busy_o(busy_a), .done_o(done_a), .done_id_o(done_id_a),
    .timeout_err_o(err_a), .jobs_done_o(jobs_a)
  );

  sobel_gcd_sched #(.TIMEOUT_CYCLES(8), .PREP_CYCLES(2)) dut_b (
    .clk_i(clk), .reset_i(reset_b), .gcd_req_i(gcd_req), .px_req_i(px_req),
    .gcd_done_i(gcd_done), .pixel_completed_i(pix_done), .clear_err_i(clear_err),
    .gcd_enable_o(gcd_en_b), .prep_allowed_o(prep_b), .pixel_enable_o(pix_b),
    .grant_o(grant_b), .busy_o(busy_b), .done_o(done_b), .done_id_o(done_id_b),
    .timeout_err_o(err_b), .jobs_done_o(jobs_b)
  );

  typedef struct packed {
    logic       id;
    logic       err;
    logic [7:0] jobs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_jobs = 0;
  exp_t mon_e;
  exp_t mon_got;

  // Scoreboard: every done_o pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done_a === 1'b1 || done_b === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected_done: done_o pulsed with no job expected");
      end else begin
        mon_e = exp_q.pop_front();
        if (done_b === 1'b1) mon_got = {done_id_b, err_b, jobs_b};
        else                 mon_got = {done_id_a, err_a, jobs_a};
        if (mon_got !== mon_e) begin
          errors++;
          $display("FAIL scoreboard_done: got id=%0b err=%0b jobs=%0d, want id=%0b err=%0b jobs=%0d",
                   mon_got.id, mon_got.err, mon_got.jobs, mon_e.id, mon_e.err, mon_e.jobs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic err, input int jobs);
    exp_t e;
    e.id   = id;
    e.err  = err;
    e.jobs = 8'(jobs);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    gcd_req = 1'b0; px_req = 1'b0; gcd_done = 1'b0; pix_done = 1'b0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gcd_en_a, prep_a, pix_a, grant_a, busy_a, done_a, done_id_a, err_a, jobs_a} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs_a: got %b, want all zero",
               {gcd_en_a, prep_a, pix_a, grant_a, busy_a, done_a, done_id_a, err_a, jobs_a});
    end
    checks++;
    if ({gcd_en_b, prep_b, pix_b, grant_b, busy_b, done_b, done_id_b, err_b, jobs_b} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs_b: got %b, want all zero",
               {gcd_en_b, prep_b, pix_b, grant_b, busy_b, done_b, done_id_b, err_b, jobs_b});
    end
    gcd_req = 1'b1; px_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant_a, busy_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_blocks_requests: got grant=%b busy=%b, want 00/0", grant_a, busy_a);
    end
    gcd_req = 1'b0; px_req = 1'b0;
    tick();
    reset_a = 1'b0;
    model_jobs = 0;
  endtask

  task automatic test_gcd_only();
    int en_cnt;
    en_cnt = 0;
    tick();
    gcd_req = 1'b1;
    model_jobs++;
    push_exp(1'b0, 1'b0, model_jobs);
    tick();
    gcd_req = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if ({grant_a, gcd_en_a, busy_a} !== 4'b0111) begin
          errors++;
          $display("FAIL gcd_grant_latency: got grant=%b en=%b busy=%b, want 01/1/1", grant_a, gcd_en_a, busy_a);
        end
      end
      if (gcd_en_a === 1'b1 && grant_a === 2'b01 && prep_a === 1'b0 && pix_a === 1'b0) en_cnt++;
      if (i == 10) gcd_done = 1'b1;
    end
    tick();
    gcd_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_a, gcd_en_a, grant_a, busy_a} !== 5'b10001) begin
      errors++;
      $display("FAIL gcd_done_state: got done=%b en=%b grant=%b busy=%b, want 1/0/00/1", done_a, gcd_en_a, grant_a, busy_a);
    end
    checks++;
    if (en_cnt !== 10) begin
      errors++;
      $display("FAIL gcd_enable_cycles: got %0d, want 10", en_cnt);
    end
    @(negedge clk);
    checks++;
    if ({done_a, busy_a} !== 2'b00) begin
      errors++;
      $display("FAIL gcd_done_pulse_width: got done=%b busy=%b, want 0/0", done_a, busy_a);
    end
  endtask

  task automatic test_pixel();
    int prep_only, run_cyc;
    prep_only = 0; run_cyc = 0;
    tick();
    px_req = 1'b1;
    model_jobs++;
    push_exp(1'b1, 1'b0, model_jobs);
    tick();
    px_req = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if ({grant_a, prep_a, pix_a, gcd_en_a} !== 5'b10100) begin
          errors++;
          $display("FAIL px_grant_latency: got grant=%b prep=%b pix=%b gcd_en=%b, want 10/1/0/0", grant_a, prep_a, pix_a, gcd_en_a);
        end
        // Completions during prep must be ignored.
        gcd_done = 1'b1; pix_done = 1'b1;
      end
      if (i == 2) begin
        gcd_done = 1'b0; pix_done = 1'b0;
      end
      if (grant_a === 2'b10 && prep_a === 1'b1 && pix_a === 1'b0) prep_only++;
      if (grant_a === 2'b10 && prep_a === 1'b1 && pix_a === 1'b1) run_cyc++;
      if (i == 7) pix_done = 1'b1;
    end
    tick();
    pix_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_a, prep_a, pix_a, grant_a} !== 5'b10000) begin
      errors++;
      $display("FAIL px_done_state: got done=%b prep=%b pix=%b grant=%b, want 1/0/0/00", done_a, prep_a, pix_a, grant_a);
    end
    checks++;
    if (prep_only !== 2) begin
      errors++;
      $display("FAIL px_prep_cycles: got %0d, want 2", prep_only);
    end
    checks++;
    if (run_cyc !== 5) begin
      errors++;
      $display("FAIL px_run_cycles: got %0d, want 5", run_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] order_v;
    logic [1:0] prev;
    int n_start, n_done, done_at, gap_bad;
    order_v = 8'd0; prev = 2'b00;
    n_start = 0; n_done = 0; done_at = 0; gap_bad = 0;
    tick();
    gcd_req = 1'b1; px_req = 1'b1; gcd_done = 1'b1; pix_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      model_jobs++;
      push_exp(1'(k % 2), 1'b0, model_jobs);
    end
    for (int i = 0; i < 80 && n_done < 4; i++) begin
      @(negedge clk);
      if (grant_a !== 2'b00 && prev === 2'b00) begin
        if (n_start < 4) order_v = {order_v[5:0], grant_a};
        if (n_start > 0 && (i - done_at) != 2) gap_bad++;
        n_start++;
      end
      if (done_a === 1'b1) begin
        n_done++;
        done_at = i;
        if (n_done == 4) begin
          gcd_req = 1'b0; px_req = 1'b0; gcd_done = 1'b0; pix_done = 1'b0;
        end
      end
      prev = grant_a;
    end
    gcd_req = 1'b0; px_req = 1'b0; gcd_done = 1'b0; pix_done = 1'b0;
    checks++;
    if (n_done !== 4) begin
      errors++;
      $display("FAIL rr_job_count: got %0d done pulses, want 4", n_done);
    end
    checks++;
    if (order_v !== 8'b01_10_01_10) begin
      errors++;
      $display("FAIL rr_grant_order: got %b, want 01100110", order_v);
    end
    checks++;
    if (gap_bad !== 0) begin
      errors++;
      $display("FAIL rr_done_to_grant_gap: got %0d bad gaps, want 0", gap_bad);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_job();
    logic found;
    found = 1'b0;
    // A completed GCD job makes Sobel the tie winner unless reset intervenes.
    tick();
    gcd_req = 1'b1;
    model_jobs++;
    push_exp(1'b0, 1'b0, model_jobs);
    tick();
    gcd_req = 1'b0; gcd_done = 1'b1;
    tick();
    gcd_done = 1'b0;
    repeat (2) @(negedge clk);
    tick();
    px_req = 1'b1;
    tick();
    px_req = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (pix_a === 1'b1) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_reach_px_run: got pixel_enable=%b, want 1 within budget", pix_a);
    end
    reset_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({gcd_en_a, prep_a, pix_a, grant_a, busy_a, done_a, done_id_a, err_a, jobs_a} !== 17'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b, want all zero",
               {gcd_en_a, prep_a, pix_a, grant_a, busy_a, done_a, done_id_a, err_a, jobs_a});
    end
    model_jobs = 0;
    tick();
    reset_a = 1'b0; gcd_req = 1'b1; px_req = 1'b1;
    model_jobs++;
    push_exp(1'b0, 1'b0, model_jobs);
    tick();
    gcd_req = 1'b0; px_req = 1'b0; gcd_done = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_a !== 2'b01) begin
      errors++;
      $display("FAIL rst_mid_tie_to_gcd: got grant=%b, want 01", grant_a);
    end
    tick();
    gcd_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int en_cnt;
    logic seen;
    en_cnt = 0; seen = 1'b0;
    reset_a = 1'b1;
    tick();
    reset_b = 1'b0;
    model_jobs = 0;
    tick();
    gcd_req = 1'b1;
    push_exp(1'b0, 1'b1, model_jobs);
    tick();
    gcd_req = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done_b === 1'b1) seen = 1'b1;
      else if (gcd_en_b === 1'b1) en_cnt++;
    end
    checks++;
    if ({seen, err_b, jobs_b} !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL tmo_abort: got done=%b err=%b jobs=%0d, want 1/1/0", seen, err_b, jobs_b);
    end
    checks++;
    if (en_cnt !== 8) begin
      errors++;
      $display("FAIL tmo_enable_cycles: got %0d, want 8", en_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({err_b, busy_b} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_sticky: got err=%b busy=%b, want 1/0", err_b, busy_b);
    end
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    @(negedge clk);
    checks++;
    if (err_b !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: got err=%b, want 0", err_b);
    end
    // Clear coinciding with a fresh abort: the set must win.
    tick();
    gcd_req = 1'b1;
    push_exp(1'b0, 1'b1, model_jobs);
    tick();
    gcd_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) clear_err = 1'b1;
    end
    tick();
    clear_err = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_b, err_b} !== 2'b11) begin
      errors++;
      $display("FAIL tmo_set_beats_clear: got done=%b err=%b, want 1/1", done_b, err_b);
    end
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  task automatic test_same_cycle();
    tick();
    gcd_req = 1'b1;
    model_jobs++;
    push_exp(1'b0, 1'b0, model_jobs);
    tick();
    gcd_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 8) gcd_done = 1'b1;
    end
    tick();
    gcd_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_b, err_b, jobs_b} !== 10'b10_0000_0001) begin
      errors++;
      $display("FAIL same_cycle_completion_wins: got done=%b err=%b jobs=%0d, want 1/0/1", done_b, err_b, jobs_b);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_gcd_only();
    test_pixel();
    test_round_robin();
    test_reset_mid_job();
    test_timeout();
    test_same_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d jobs never reported, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
